// File: rtl/cmp_pkg.sv
// Shared types and helpers for the comparator hysteresis monitor.
// Holds the FSM state encoding, default sizing and the flag legality check.
package cmp_pkg;

  typedef enum logic [1:0] {
    BELOW   = 2'd0,
    RISING  = 2'd1,
    ABOVE   = 2'd2,
    FALLING = 2'd3
  } state_t;

  localparam int DEBOUNCE_DEF = 4;
  localparam int CNT_W_DEF    = 4;
  localparam int EVT_W_DEF    = 8;

  // Flags are ordered {equal, lower, greater}.
  function automatic logic flags_onehot(input logic [2:0] flags);
    return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  endfunction

endpackage

// File: rtl/cmp_sat_counter.sv
// Saturating up-counter; clear has priority over increment and holds at all-ones.
module cmp_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cmp_hysteresis_monitor.sv
// Debounces comparator equal/lower/greater flags with a 4-state hysteresis FSM and
// reports a registered level, crossing pulses, a crossing count and a sticky flag error.
module cmp_hysteresis_monitor
  import cmp_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int EVT_W    = EVT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             equal,
  input  logic             lower,
  input  logic             greater,
  input  logic             clear,
  output logic             above,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [EVT_W-1:0] evt_count,
  output logic             flag_err
);

  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             above_q, above_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             err_q, err_d;
  logic             legal;
  logic             qual;

  assign legal   = flags_onehot({equal, lower, greater});
  assign qual    = in_valid && legal;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BELOW;
      cnt_q   <= '0;
      above_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      above_q <= above_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      err_q   <= err_d;
    end
  end

  // NOTE: defaults at the top of every combinational block keep all paths assigned, so no latches form.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (qual) begin
      unique case (state_q)
        BELOW: begin
          cnt_d = '0;
          if (greater) begin
            if (DEB == CNT_W'(1)) state_d = ABOVE;
            else begin
              state_d = RISING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        RISING: begin
          if (greater) begin
            if (cnt_inc == DEB) begin
              state_d = ABOVE;
              cnt_d   = '0;
            end else cnt_d = cnt_inc;
          end else if (lower) begin
            state_d = BELOW;
            cnt_d   = '0;
          end
        end
        ABOVE: begin
          cnt_d = '0;
          if (lower) begin
            if (DEB == CNT_W'(1)) state_d = BELOW;
            else begin
              state_d = FALLING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        FALLING: begin
          if (lower) begin
            if (cnt_inc == DEB) begin
              state_d = BELOW;
              cnt_d   = '0;
            end else cnt_d = cnt_inc;
          end else if (greater) begin
            state_d = ABOVE;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Pulses mark genuine crossings only; aborted debounces return to their own side silently.
  always_comb begin
    above_d = (state_d == ABOVE) || (state_d == FALLING);
    rise_d  = (state_d == ABOVE) && ((state_q == BELOW) || (state_q == RISING));
    fall_d  = (state_d == BELOW) && ((state_q == ABOVE) || (state_q == FALLING));
    err_d   = err_q;
    if (in_valid && !legal) err_d = 1'b1;
    else if (clear)         err_d = 1'b0;
  end

  cmp_sat_counter #(.W(EVT_W)) u_evt_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (rise_d || fall_d),
    .clr_i   (clear),
    .count_o (evt_count)
  );

  assign above      = above_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign flag_err   = err_q;

endmodule
